// File: rtl/mips_io_pkg.sv
// Shared definitions for the MIPS I/O port peripheral.
//   - interrupt FSM state encoding
//   - bit positions inside the sticky error vector
//   - default data word width (matches the 16-bit core datapath)
package mips_io_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        SERV = 2'd2
    } intr_state_t;

    localparam int ERR_RD_EMPTY = 0;
    localparam int ERR_WR_BUSY  = 1;

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO holding inbound device words until the core reads them.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   i_push/i_push_data - write request; ignored while full
//   i_pop           - read request; ignored while empty
//   o_rd_data       - registered head word, updated only on an accepted pop
//   o_full/o_empty  - occupancy flags
//   o_count         - occupancy, 0..DEPTH
module io_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_count   = r_count;
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_push_data;
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            o_rd_data <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                o_rd_data <= r_mem[r_rd_ptr];
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mips_io_port.sv
// Device end of the 16-bit MIPS core I/O interface.
//   Core side  : cpu_data_out/cpu_wr (write), cpu_rd/cpu_data_in (read),
//                interrupt/intr_ack, rx_count, tx_busy, err/err_clr
//   Device side: dev_in_* (inbound valid/ready), dev_out_* (outbound valid/ready)
// Inbound words queue in a FIFO; an interrupt is requested once THRESH words
// are waiting. One outbound word is held until the device accepts it.
module mips_io_port
    import mips_io_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = 4,
    parameter int THRESH = 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cpu_data_out,
    input  logic             cpu_wr,
    input  logic             cpu_rd,
    output logic [WIDTH-1:0] cpu_data_in,
    output logic             interrupt,
    input  logic             intr_ack,
    output logic [CW-1:0]    rx_count,
    output logic             tx_busy,
    output logic [1:0]       err,
    input  logic             err_clr,
    input  logic [WIDTH-1:0] dev_in_data,
    input  logic             dev_in_valid,
    output logic             dev_in_ready,
    output logic [WIDTH-1:0] dev_out_data,
    output logic             dev_out_valid,
    input  logic             dev_out_ready
);

    intr_state_t r_state;
    logic        w_full;
    logic        w_empty;
    logic [1:0]  w_err_evt;

    assign dev_in_ready = !w_full;
    assign tx_busy      = dev_out_valid;

    io_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (dev_in_valid),
        .i_push_data (dev_in_data),
        .i_pop       (cpu_rd),
        .o_rd_data   (cpu_data_in),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (rx_count)
    );

    // SERV blocks re-requests until the core has fully drained the FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            interrupt <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (rx_count >= CW'(THRESH)) begin
                    r_state   <= PEND;
                    interrupt <= 1'b1;
                end
                PEND: if (intr_ack) begin
                    r_state   <= SERV;
                    interrupt <= 1'b0;
                end
                SERV: if (rx_count == '0) begin
                    r_state   <= IDLE;
                    interrupt <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    interrupt <= 1'b0;
                end
            endcase
        end
    end

    // A write on the handshake edge still sees the old busy flag and is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dev_out_valid <= 1'b0;
            dev_out_data  <= '0;
        end else if (dev_out_valid && dev_out_ready) begin
            dev_out_valid <= 1'b0;
        end else if (!dev_out_valid && cpu_wr) begin
            dev_out_valid <= 1'b1;
            dev_out_data  <= cpu_data_out;
        end
    end

    always_comb begin
        w_err_evt               = '0;
        w_err_evt[ERR_RD_EMPTY] = cpu_rd && w_empty;
        w_err_evt[ERR_WR_BUSY]  = cpu_wr && dev_out_valid;
    end

    // New events are OR-ed after the clear so they win over err_clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err <= '0;
        else
            err <= (err_clr ? 2'b00 : err) | w_err_evt;
    end

endmodule

// File: tb/tb_mips_io_port.sv
module tb_mips_io_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_data_out;
  logic        cpu_wr, cpu_rd, intr_ack, err_clr;
  logic [15:0] dev_in_data;
  logic        dev_in_valid, dev_out_ready;

  logic [15:0] a_cpu_data_in, a_dev_out_data, b_cpu_data_in, b_dev_out_data;
  logic        a_interrupt, a_tx_busy, a_dev_in_ready, a_dev_out_valid;
  logic        b_interrupt, b_tx_busy, b_dev_in_ready, b_dev_out_valid;
  logic [2:0]  a_rx_count, b_rx_count;
  logic [1:0]  a_err, b_err;

  int total = 0;
  int bad   = 0;
  int hs    = 0;
  logic [15:0] last_rd = '0;
  logic [15:0] rxq[$];
  logic [15:0] txq[$];

  always #5 clk = ~clk;

  mips_io_port #(.WIDTH(16), .DEPTH(4), .THRESH(1)) dut1 (
    .clk(clk), .reset(reset), .cpu_data_out(cpu_data_out), .cpu_wr(cpu_wr),
    .cpu_rd(cpu_rd), .cpu_data_in(a_cpu_data_in), .interrupt(a_interrupt),
    .intr_ack(intr_ack), .rx_count(a_rx_count), .tx_busy(a_tx_busy), .err(a_err),
    .err_clr(err_clr), .dev_in_data(dev_in_data), .dev_in_valid(dev_in_valid),
    .dev_in_ready(a_dev_in_ready), .dev_out_data(a_dev_out_data),
    .dev_out_valid(a_dev_out_valid), .dev_out_ready(dev_out_ready)
  );

  mips_io_port #(.WIDTH(16), .DEPTH(4), .THRESH(3)) dut3 (
    .clk(clk), .reset(reset), .cpu_data_out(cpu_data_out), .cpu_wr(cpu_wr),
    .cpu_rd(cpu_rd), .cpu_data_in(b_cpu_data_in), .interrupt(b_interrupt),
    .intr_ack(intr_ack), .rx_count(b_rx_count), .tx_busy(b_tx_busy), .err(b_err),
    .err_clr(err_clr), .dev_in_data(dev_in_data), .dev_in_valid(dev_in_valid),
    .dev_in_ready(b_dev_in_ready), .dev_out_data(b_dev_out_data),
    .dev_out_valid(b_dev_out_valid), .dev_out_ready(dev_out_ready)
  );

  // Outbound scoreboard: a handshake happens on the next rising edge.
  always @(negedge clk) begin
    if (reset && a_dev_out_valid && dev_out_ready) begin
      total++;
      hs++;
      if (txq.size() == 0) begin
        bad++;
        $display("FAIL tx_unexpected: got %h, none expected", a_dev_out_data);
      end else begin
        if (a_dev_out_data !== txq[0]) begin
          bad++;
          $display("FAIL tx_data: got %h want %h", a_dev_out_data, txq[0]);
        end
        void'(txq.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    rxq.delete();
    txq.delete();
    tick();
  endtask

  task automatic push_word(input logic [15:0] w);
    int n;
    dev_in_valid = 1'b1;
    dev_in_data  = w;
    n = 0;
    while (!a_dev_in_ready && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (!a_dev_in_ready) begin
      bad++;
      $display("FAIL push_ready_timeout: dev_in_ready=%b want 1", a_dev_in_ready);
    end else begin
      rxq.push_back(w);
      tick();
    end
    dev_in_valid = 1'b0;
  endtask

  task automatic cpu_read();
    logic [15:0] exp;
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    exp = (rxq.size() != 0) ? rxq.pop_front() : last_rd;
    total += 2;
    if (a_cpu_data_in !== exp) begin
      bad++;
      $display("FAIL rd_data_t1: got %h want %h", a_cpu_data_in, exp);
    end
    if (b_cpu_data_in !== exp) begin
      bad++;
      $display("FAIL rd_data_t3: got %h want %h", b_cpu_data_in, exp);
    end
    last_rd = exp;
  endtask

  task automatic test_reset();
    push_word(16'h5555);
    push_word(16'h6666);
    cpu_data_out = 16'hAAAA;
    cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
    reset = 1'b0;
    #2;
    total += 5;
    if (a_interrupt !== 1'b0) begin bad++; $display("FAIL rst_intr: got %b want 0", a_interrupt); end
    if (a_rx_count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", a_rx_count); end
    if (a_dev_out_valid !== 1'b0 || a_dev_out_data !== 16'h0) begin
      bad++; $display("FAIL rst_tx: got v=%b d=%h want 0/0000", a_dev_out_valid, a_dev_out_data);
    end
    if (a_err !== 2'b00) begin bad++; $display("FAIL rst_err: got %b want 00", a_err); end
    if (a_cpu_data_in !== 16'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0000", a_cpu_data_in); end
    tick();
    reset = 1'b1;
    rxq.delete();
    txq.delete();
    last_rd = '0;
    tick();
    total += 2;
    if (a_dev_in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", a_dev_in_ready); end
    if (a_tx_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", a_tx_busy); end
  endtask

  task automatic test_basic();
    push_word(16'h1234);
    push_word(16'hABCD);
    total++;
    if (a_interrupt !== 1'b1) begin bad++; $display("FAIL basic_intr: got %b want 1", a_interrupt); end
    intr_ack = 1'b1;
    tick();
    intr_ack = 1'b0;
    total++;
    if (a_interrupt !== 1'b0) begin bad++; $display("FAIL basic_ack: got %b want 0", a_interrupt); end
    cpu_read();
    cpu_read();
    total++;
    if (a_rx_count !== 3'd0) begin bad++; $display("FAIL basic_drain: got %0d want 0", a_rx_count); end
    tick();
    push_word(16'h0F0F);
    tick();
    total++;
    if (a_interrupt !== 1'b1) begin bad++; $display("FAIL basic_rearm: got %b want 1", a_interrupt); end
  endtask

  task automatic test_full();
    pulse_reset();
    for (int i = 1; i <= 4; i++) push_word(16'h1000 + 16'(i));
    total += 2;
    if (a_rx_count !== 3'd4) begin bad++; $display("FAIL full_count: got %0d want 4", a_rx_count); end
    if (a_dev_in_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", a_dev_in_ready); end
    dev_in_valid = 1'b1;
    dev_in_data  = 16'h1005;
    tick();
    total++;
    if (a_rx_count !== 3'd4) begin bad++; $display("FAIL full_hold: got %0d want 4", a_rx_count); end
    cpu_read();
    rxq.push_back(16'h1005);
    tick();
    dev_in_valid = 1'b0;
    total++;
    if (a_rx_count !== 3'd4) begin bad++; $display("FAIL full_refill: got %0d want 4", a_rx_count); end
    for (int i = 0; i < 4; i++) cpu_read();
    total++;
    if (a_rx_count !== 3'd0) begin bad++; $display("FAIL full_drain: got %0d want 0", a_rx_count); end
  endtask

  task automatic test_rd_empty();
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    total += 2;
    if (a_cpu_data_in !== last_rd) begin bad++; $display("FAIL empty_rdata: got %h want %h", a_cpu_data_in, last_rd); end
    if (a_err !== 2'b01) begin bad++; $display("FAIL empty_err: got %b want 01", a_err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if (a_err !== 2'b00) begin bad++; $display("FAIL err_clear: got %b want 00", a_err); end
    cpu_rd = 1'b1;
    err_clr = 1'b1;
    tick();
    cpu_rd = 1'b0;
    err_clr = 1'b0;
    total++;
    if (a_err !== 2'b01) begin bad++; $display("FAIL err_evt_wins: got %b want 01", a_err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    dev_in_valid = 1'b1;
    dev_in_data  = 16'h7777;
    cpu_rd = 1'b1;
    tick();
    dev_in_valid = 1'b0;
    cpu_rd = 1'b0;
    rxq.push_back(16'h7777);
    total += 3;
    if (a_rx_count !== 3'd1) begin bad++; $display("FAIL empty_pushpop_count: got %0d want 1", a_rx_count); end
    if (a_err !== 2'b01) begin bad++; $display("FAIL empty_pushpop_err: got %b want 01", a_err); end
    if (a_cpu_data_in !== last_rd) begin bad++; $display("FAIL empty_pushpop_rdata: got %h want %h", a_cpu_data_in, last_rd); end
    cpu_read();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_tx();
    int hs0;
    hs0 = hs;
    dev_out_ready = 1'b0;
    cpu_data_out = 16'h00FF;
    cpu_wr = 1'b1;
    txq.push_back(16'h00FF);
    tick();
    cpu_wr = 1'b0;
    total += 2;
    if (a_dev_out_valid !== 1'b1 || a_tx_busy !== 1'b1) begin
      bad++; $display("FAIL tx_load_valid: got v=%b busy=%b want 1/1", a_dev_out_valid, a_tx_busy);
    end
    if (a_dev_out_data !== 16'h00FF) begin bad++; $display("FAIL tx_load_data: got %h want 00ff", a_dev_out_data); end
    cpu_data_out = 16'h1111;
    cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
    total += 2;
    if (a_err !== 2'b10) begin bad++; $display("FAIL tx_busy_err: got %b want 10", a_err); end
    if (a_dev_out_data !== 16'h00FF) begin bad++; $display("FAIL tx_stable: got %h want 00ff", a_dev_out_data); end
    dev_out_ready = 1'b1;
    tick();
    dev_out_ready = 1'b0;
    tick();
    total += 2;
    if (a_dev_out_valid !== 1'b0) begin bad++; $display("FAIL tx_done_valid: got %b want 0", a_dev_out_valid); end
    if (hs - hs0 !== 1) begin bad++; $display("FAIL tx_once: got %0d handshakes want 1", hs - hs0); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    cpu_data_out = 16'h2222;
    cpu_wr = 1'b1;
    txq.push_back(16'h2222);
    tick();
    cpu_data_out = 16'h3333;
    dev_out_ready = 1'b1;
    tick();
    cpu_wr = 1'b0;
    dev_out_ready = 1'b0;
    total += 3;
    if (a_dev_out_valid !== 1'b0) begin bad++; $display("FAIL tx_race_valid: got %b want 0", a_dev_out_valid); end
    if (a_err !== 2'b10) begin bad++; $display("FAIL tx_race_err: got %b want 10", a_err); end
    if (hs - hs0 !== 2) begin bad++; $display("FAIL tx_race_count: got %0d handshakes want 2", hs - hs0); end
  endtask

  task automatic test_thresh3();
    pulse_reset();
    push_word(16'hA001);
    push_word(16'hA002);
    tick();
    tick();
    total++;
    if (b_interrupt !== 1'b0) begin bad++; $display("FAIL th3_below: got %b want 0", b_interrupt); end
    push_word(16'hA003);
    tick();
    total++;
    if (b_interrupt !== 1'b1) begin bad++; $display("FAIL th3_reach: got %b want 1", b_interrupt); end
    intr_ack = 1'b1;
    tick();
    intr_ack = 1'b0;
    total++;
    if (b_interrupt !== 1'b0) begin bad++; $display("FAIL th3_ack: got %b want 0", b_interrupt); end
    push_word(16'hA004);
    tick();
    tick();
    total++;
    if (b_interrupt !== 1'b0) begin bad++; $display("FAIL th3_serv_push: got %b want 0", b_interrupt); end
    for (int i = 0; i < 4; i++) cpu_read();
    tick();
    total += 2;
    if (b_rx_count !== 3'd0) begin bad++; $display("FAIL th3_drain: got %0d want 0", b_rx_count); end
    if (b_interrupt !== 1'b0) begin bad++; $display("FAIL th3_idle: got %b want 0", b_interrupt); end
    for (int i = 0; i < 3; i++) push_word(16'hB000 + 16'(i));
    tick();
    total++;
    if (b_interrupt !== 1'b1) begin bad++; $display("FAIL th3_rearm: got %b want 1", b_interrupt); end
  endtask

  initial begin
    reset = 1'b0;
    cpu_data_out = '0;
    cpu_wr = 1'b0;
    cpu_rd = 1'b0;
    intr_ack = 1'b0;
    err_clr = 1'b0;
    dev_in_data = '0;
    dev_in_valid = 1'b0;
    dev_out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_full();
    test_rd_empty();
    test_tx();
    test_thresh3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_io_port.md
Name: mips_io_port

Overview:
- Peripheral that forms the device end of the 16-bit MIPS core's I/O interface.
- Consumes the core's data_out, supplies the core's data_in and drives the core's interrupt input.
- Buffers inbound words from an external device in a small FIFO and raises an interrupt when enough words are waiting.
- Holds one outbound word from the core and presents it to the external device with a valid/ready handshake.

Parameters:
- WIDTH, 16, data word width; matches the core datapath.
- DEPTH, 4, RX FIFO entries; power of two, 2..16.
- THRESH, 1, RX occupancy (1..DEPTH) at which an interrupt is requested.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- cpu_data_out  input  WIDTH  word written by the core (core data_out).
- cpu_wr  input  1  core write strobe; one cycle per word.
- cpu_rd  input  1  core read strobe; pops one RX word.
- cpu_data_in  output  WIDTH  registered word returned to the core (core data_in).
- interrupt  output  1  interrupt request to the core.
- intr_ack  input  1  core acknowledge of interrupt; one-cycle pulse.
- rx_count  output  $clog2(DEPTH)+1  current RX occupancy.
- tx_busy  output  1  outbound holding register occupied.
- err  output  2  sticky flags: [0] read on empty, [1] write while tx_busy.
- err_clr  input  1  clears err.
- dev_in_data  input  WIDTH  inbound word from the device.
- dev_in_valid  input  1  device offers dev_in_data.
- dev_in_ready  output  1  FIFO can accept a word; equals !full.
- dev_out_data  output  WIDTH  outbound word to the device.
- dev_out_valid  output  1  dev_out_data is valid.
- dev_out_ready  input  1  device accepts dev_out_data.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty, rx_count=0, cpu_data_in=0.
  - interrupt=0, FSM in IDLE.
  - dev_out_valid=0, dev_out_data=0, tx_busy=0, err=0.
  - dev_in_ready=1 once reset is released.
  - A reset mid-transfer discards all buffered words.
- RX push: occurs when dev_in_valid && dev_in_ready.
  - When full, dev_in_ready=0 and the device must hold its word.
- RX pop: cpu_rd while not empty.
  - cpu_data_in takes the head word at that edge, i.e. it is valid the cycle after cpu_rd.
  - cpu_rd while empty leaves cpu_data_in unchanged and sets err[0].
- Simultaneous push and pop:
  - Not empty and not full: both occur and rx_count is unchanged.
  - Empty: only the push occurs and err[0] is set.
  - Full: no push is possible because dev_in_ready=0; the pop occurs.
- Pointers wrap modulo DEPTH; rx_count ranges 0..DEPTH.
- Interrupt FSM:
  - IDLE (interrupt=0): moves to PEND when rx_count >= THRESH.
  - PEND (interrupt=1): moves to SERV on intr_ack.
  - SERV (interrupt=0): moves to IDLE when rx_count==0; no re-request while the core is draining.
  - intr_ack in IDLE or SERV is ignored.
  - If intr_ack arrives on the same edge that drains the FIFO, the FSM moves to SERV, then to IDLE the next cycle.
- TX path:
  - cpu_wr with tx_busy=0 loads dev_out_data <= cpu_data_out and sets dev_out_valid=1 on the next edge.
  - The transfer completes on the edge where dev_out_valid && dev_out_ready; dev_out_valid then drops.
  - tx_busy equals dev_out_valid.
  - cpu_wr while tx_busy=1 drops the word and sets err[1].
  - cpu_wr on the same edge as a completing handshake is still dropped, because tx_busy is sampled before the edge.
  - dev_out_data stays stable while dev_out_valid=1.
- err_clr clears err. If an error event and err_clr occur in the same cycle, the event wins.
- All outputs are registered except dev_in_ready and rx_count (driven from FIFO state).

Decomposition:
- Shared package mips_io_pkg holds:
  - the interrupt state encoding (IDLE, PEND, SERV, 2 bits);
  - error bit index constants ERR_RD_EMPTY=0 and ERR_WR_BUSY=1;
  - the default WIDTH.
- One sub-module: io_sync_fifo.
  - Parameters WIDTH and DEPTH.
  - Ports: push/pop, full/empty and count.
  - Registered read data with a pop-when-empty guard.
- The top level contains the interrupt FSM, the TX holding register and the error flags.

Test Plan:
- Reset pulse low for 2 cycles mid-stream -> interrupt=0, rx_count=0, dev_out_valid=0, err=0, dev_in_ready=1 after release.
- Device pushes 0x1234, 0xABCD with THRESH=1 -> interrupt=1 the cycle after first push; intr_ack -> interrupt=0; two cpu_rd -> cpu_data_in 0x1234 then 0xABCD; FSM returns to IDLE when rx_count=0.
- Push 5 words with DEPTH=4 and no reads -> dev_in_ready=0 at rx_count=4, 5th word held; one cpu_rd -> 5th word accepted, rx_count stays 4, order preserved.
- cpu_rd on empty FIFO -> cpu_data_in unchanged, err=2'b01; err_clr -> err=0.
- cpu_wr 0x00FF with dev_out_ready=0 -> dev_out_valid=1, data 0x00FF; second cpu_wr 0x1111 -> dropped, err[1]=1; dev_out_ready=1 -> valid drops, 0x00FF transferred once.
- THRESH=3: push 2 words -> interrupt stays 0; 3rd push -> interrupt=1; ack, then push during SERV -> no new interrupt until drained to 0.
